// File: rtl/cdc_register_arbiter_pkg.sv
// Shared types and constants for the cdc_register write-port arbiter.
// The FSM state encoding and the completed-write counter width live here.
package cdc_register_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam int writes_issued_width = 16;

endpackage

// File: rtl/cdc_register_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request after
// last_grant (wrapping modulo num_requesters) wins.
module rr_arbiter #(
   parameter int num_requesters = 4,
   parameter int id_width       = $clog2(num_requesters)
) (
   input  logic [num_requesters-1:0] req,
   input  logic [id_width-1:0]       last_grant,
   output logic                      valid,
   output logic [id_width-1:0]       winner
);

   // Walk the offsets from farthest to nearest so the nearest asserted request wins.
   always_comb begin
      int idx;
      valid  = |req;
      winner = '0;
      idx    = 0;
      for (int off = num_requesters; off >= 1; off--) begin
         idx = (int'(last_grant) + off) % num_requesters;
         if (req[idx]) begin
            winner = id_width'(idx);
         end
      end
   end

endmodule

// File: rtl/cdc_register_arbiter.sv
// Shares one cdc_register write port among several requesters: round-robin
// grant in IDLE, hold the write in ISSUE, wait for the handshake in DRAIN.
module cdc_register_arbiter
   import cdc_register_arbiter_pkg::*;
#(
   parameter  int num_requesters = 4,
   parameter  int data_width     = 32,
   localparam int id_width       = $clog2(num_requesters)
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic [num_requesters-1:0]                  req,
   input  logic [num_requesters-1:0][data_width-1:0]  req_data,
   output logic [num_requesters-1:0]                  req_ack,
   output logic [id_width+data_width-1:0]             reg_wr_data,
   output logic                                       reg_wr,
   input  logic                                       reg_wr_ready,
   output logic                                       busy,
   output logic [writes_issued_width-1:0]             writes_issued
);

   arb_state_t                     state_reg, state_next;
   logic [id_width-1:0]            last_grant_reg;
   logic [id_width-1:0]            id_reg;
   logic [data_width-1:0]          payload_reg;
   logic [writes_issued_width-1:0] count_reg;
   logic [id_width-1:0]            winner;
   logic                           arb_valid;
   logic                           grant;

   rr_arbiter #(
      .num_requesters (num_requesters),
      .id_width       (id_width)
   ) u_rr_arbiter (
      .req        (req),
      .last_grant (last_grant_reg),
      .valid      (arb_valid),
      .winner     (winner)
   );

   // Gating with reset_n keeps req_ack quiet while reset is held.
   assign grant = reset_n && (state_reg == IDLE) && reg_wr_ready && arb_valid;

   always_comb begin
      state_next = state_reg;
      req_ack    = '0;
      case (state_reg)
         IDLE: begin
            if (grant) begin
               state_next      = ISSUE;
               req_ack[winner] = 1'b1;
            end
         end
         ISSUE: begin
            if (reg_wr_ready) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (reg_wr_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= id_width'(num_requesters - 1);
         id_reg         <= '0;
         payload_reg    <= '0;
         count_reg      <= '0;
      end else begin
         state_reg <= state_next;
         if (grant) begin
            last_grant_reg <= winner;
            id_reg         <= winner;
            payload_reg    <= req_data[winner];
         end
         if ((state_reg == ISSUE) && reg_wr_ready) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign reg_wr        = (state_reg == ISSUE);
   assign busy          = (state_reg != IDLE);
   assign reg_wr_data   = {id_reg, payload_reg};
   assign writes_issued = count_reg;

endmodule

// File: doc/cdc_register_arbiter.md
CDC_REGISTER_ARBITER -- requirements
Module: cdc_register_arbiter

Interface
REQ-001 Parameter num_requesters, default 4, number of write requesters sharing one cdc_register write port (range 2..16).
REQ-002 Parameter data_width, default 32, payload width per requester.
REQ-003 Localparam id_width = $clog2(num_requesters), source-id field width.
REQ-004 Port clk  input  1  single clock; connects to the cdc_register wr_clk.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port req  input  num_requesters  per-requester write request, held until its ack.
REQ-007 Port req_data  input  [num_requesters][data_width]  per-requester payload, stable while req is high.
REQ-008 Port req_ack  output  num_requesters  one-cycle pulse: payload captured, requester may drop or change req.
REQ-009 Port reg_wr_data  output  id_width+data_width  {grant id, payload}; connects to cdc_register wr_data.
REQ-010 Port reg_wr  output  1  write strobe to cdc_register wr.
REQ-011 Port reg_wr_ready  input  1  cdc_register wr_ready.
REQ-012 Port busy  output  1  high in any state other than IDLE.
REQ-013 Port writes_issued  output  16  count of completed writes, wraps 0xFFFF->0x0000.

Function
REQ-014 FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on grant, ISSUE->DRAIN on reg_wr&&reg_wr_ready, DRAIN->IDLE when reg_wr_ready==1.
REQ-015 Grant occurs in IDLE only, when reg_wr_ready==1 and |req; no grant otherwise.
REQ-016 Arbitration round-robin: search starts at last_grant+1 modulo num_requesters; first asserted req wins.
REQ-017 On grant, same cycle: req_ack[winner]=1 (combinational, single bit), payload and id latched at that clock edge, last_grant<=winner.
REQ-018 At most one req_ack bit high in any cycle; req_ack never high outside IDLE.
REQ-019 In ISSUE: reg_wr=1 with latched {id,payload} on reg_wr_data; reg_wr held high until reg_wr_ready samples 1.
REQ-020 reg_wr is registered-state-decoded, high only in ISSUE; exactly one accepted write per grant.
REQ-021 reg_wr_data holds latched value from grant until next grant (not cleared in DRAIN/IDLE).
REQ-022 DRAIN waits for reg_wr_ready to return high (handshake round-trip complete); no grant from DRAIN.
REQ-023 writes_issued increments by 1 on the cycle reg_wr&&reg_wr_ready.
REQ-024 Latency: req rising in IDLE with ready high -> ack same cycle -> reg_wr next cycle.
REQ-025 Requester dropping req before ack: request discarded, no ack, no write.
REQ-026 Simultaneous requests: served in rotating order; a continuously requesting requester waits at most num_requesters-1 grants.

Reset
REQ-027 Asynchronous assertion of reset_n=0: state=IDLE, last_grant=num_requesters-1 (requester 0 highest priority first), latched payload/id=0, writes_issued=0.
REQ-028 During reset: reg_wr=0, req_ack=0, busy=0, reg_wr_data=0.
REQ-029 Reset mid-ISSUE/DRAIN abandons the transfer without retraction; after release, IDLE still gates grants on reg_wr_ready, so an in-flight cdc_register handshake completes before the next write.

Structure
REQ-030 Package cdc_register_arbiter_pkg holds the state enum (IDLE, ISSUE, DRAIN) and the writes_issued width constant.
REQ-031 Sub-module rr_arbiter (combinational: req vector, last_grant -> valid, winner index) is instantiated once.
REQ-032 Top module holds FSM, payload latch, last_grant register and counter; intended to sit beside a cdc_register with data_width = id_width+data_width.

Verification
REQ-033 Reset release, req=4'b0001, data0=0x1234_5678, ready=1 -> ack[0] same cycle, next cycle reg_wr=1, reg_wr_data={2'd0,0x12345678}, writes_issued=1.
REQ-034 req=4'b1111 held, ready toggling as a real cdc_register -> grants in order 0,1,2,3,0; never two acks in one cycle.
REQ-035 req=4'b0100 while reg_wr_ready=0 -> no ack, busy=0; ready rises -> ack[2] that cycle.
REQ-036 ISSUE with reg_wr_ready held 0 for 5 cycles -> reg_wr high all 5 cycles, payload stable, count unchanged until accept.
REQ-037 reset_n pulsed low in DRAIN -> outputs to reset values immediately (asynchronous); after release with ready=0, no grant until ready=1.
REQ-038 65536 back-to-back writes from one requester -> writes_issued wraps to 0x0000.
